lcd_frame_sequencer: RTL and testbench
======================================

# lcd_frame_sequencer

Frame-level controller for the LT24 pixel port in the scope datapath. On each frame request it raster-scans the 240×320 panel: it fetches one captured sample per row from the sample buffer, then streams that row's pixels to `LT24Display` through the `pixelWrite`/`pixelReady` handshake. Each pixel is coloured as trace, graticule or background. It replaces free-running x/y counters with a sequenced, stall-safe scan and reports frame busy/done to the capture side.

## Interface
- `WIDTH`, 240: panel columns, amplitude axis.
- `HEIGHT`, 320: panel rows, time axis, one sample per row.
- `SAMPLE_W`, 8: sample width.
- `GRID_DIV`, 40: graticule pitch in pixels.
- `TRACE_COL`, 16'h07E0: RGB565 trace colour.
- `GRID_COL`, 16'h4208: RGB565 graticule colour.
- `BG_COL`, 16'h0000: RGB565 background colour.
- `clock`  in  1  system clock, 50 MHz.
- `rstApp`  in  1  synchronous, active-high reset; driven from the display driver's `resetApp`.
- `frameStart`  in  1  single-cycle frame request.
- `frameBusy`  out  1  high from frame acceptance until the last pixel is accepted.
- `frameDone`  out  1  one-cycle pulse after the last pixel is accepted.
- `sampRd`  out  1  sample-buffer read strobe.
- `sampAddr`  out  9  sample index, equal to the row.
- `sampData`  in  SAMPLE_W  sample read data, valid in the cycle after `sampRd`.
- `xAddr`  out  8  pixel column to the driver.
- `yAddr`  out  9  pixel row to the driver.
- `pixelData`  out  16  RGB565 pixel to the driver.
- `pixelWrite`  out  1  pixel valid to the driver.
- `pixelReady`  in  1  driver can accept a pixel.

## Operation
- **States:**
  - IDLE → FETCH when `frameStart`=1.
  - FETCH (one cycle): `sampRd`=1, `sampAddr`=current row.
  - FETCH → LOAD.
  - LOAD (one cycle): capture `sampData`.
  - LOAD → WRITE.
  - WRITE → FETCH after the last column of any row except the last.
  - WRITE → DONE after the last column of the last row.
  - DONE → IDLE.
- **Transfer rule:** a pixel transfers when `pixelWrite`=1 and `pixelReady`=1 in the same cycle.
  - In WRITE, `pixelWrite`=1.
  - While `pixelReady`=0, `xAddr`, `yAddr` and `pixelData` hold stable.
  - Each transfer advances the column; the transfer at column WIDTH-1 ends the row.
- **Amplitude mapping:** `amp` = min(`sampData`, WIDTH-1), saturating.
  - `cur` is the amplitude of the current row; `prev` is the amplitude of the previous row.
  - At row 0, `prev` = `cur`.
  - `lo` = min(`prev`, `cur`); `hi` = max(`prev`, `cur`). Both are registered in LOAD.
- **Colour priority:**
  - TRACE_COL when `lo` ≤ x ≤ `hi`. This gives a continuous vertical join between rows.
  - Otherwise GRID_COL when on the graticule.
  - Otherwise BG_COL.
- **Graticule:** x mod GRID_DIV = 0, or y mod GRID_DIV = 0, or x = WIDTH-1, or y = HEIGHT-1.
  - Computed with wrap-at-GRID_DIV phase counters, not a divider.
- `frameStart` outside IDLE is ignored; it is not queued.
- `frameDone` pulses in DONE. `frameBusy`=1 in FETCH, LOAD and WRITE.
- **Reset, including mid-frame:** the next cycle is in IDLE and every output is 0. A partial frame is abandoned.

## Timing
- Reset value of every output is 0: `frameBusy`, `frameDone`, `sampRd`, `sampAddr`, `xAddr`, `yAddr`, `pixelData`, `pixelWrite`.
- **Frame start:** with `frameStart` sampled high at edge k:
  - `sampRd`=1 in cycle k+1.
  - LOAD in cycle k+2.
  - First `pixelWrite`=1 in cycle k+3, at x=0, y=0.
- **Row overhead:** 2 cycles (FETCH + LOAD), with `pixelWrite`=0.
- **Frame length:** with `pixelReady` held at 1, one frame is 320×(240+2)=77,440 cycles from the first FETCH to the last transfer. `frameDone` follows one cycle after the last transfer.
- **Outputs:** all outputs are registered. `pixelData` is registered together with `xAddr`/`yAddr`.
- **Stalls:** a stall of any length on `pixelReady` loses no pixel and duplicates no pixel.

## Configuration
- `LCD_SCOPE_GRID_EN` defined: graticule is drawn as above, and the phase counters are instantiated.
- `LCD_SCOPE_GRID_EN` undefined: non-trace pixels are BG_COL, the phase counters are removed, and the `GRID_COL` parameter is unused.

## Structure
- **Package `lcd_scope_pkg`:**
  - LCD_W/LCD_H constants.
  - State enum {IDLE, FETCH, LOAD, WRITE, DONE}.
  - Default colour constants.
- **Sub-module `raster_scan_counter`:**
  - Column/row counter pair with enable, row-end and frame-end flags.
  - Carries the optional graticule phase counters.
- The FSM, sample registers and colour mux stay in `lcd_frame_sequencer`.

## Test plan
- **Reset:** reset, then `frameStart` with `pixelReady`=1 and all samples =100.
  - `pixelWrite` first high 3 cycles after the start.
  - Exactly 76,800 transfers; `frameDone` 77,441 cycles after the start.
  - Column 100 is TRACE_COL in every row; (0,1) is GRID_COL; (1,1) is BG_COL.
- **Stall:** random `pixelReady` with 30% low duty.
  - Transfer sequence is identical to the unstalled run.
  - Address and data stay stable throughout every stall.
- **Saturation and join:** row 4 sample =250, row 5 sample =10.
  - Row 4 trace spans x 239 only after the join, i.e. `lo`/`hi` taken from rows 3/4.
  - Row 5 trace spans x 10..239.
- **Busy start and mid-frame reset:** `frameStart` pulsed during WRITE is ignored.
  - `rstApp` asserted mid-row 100: all outputs are 0 the next cycle and the state is IDLE.
  - A new frame then restarts at row 0.
- **Grid compiled out:** with `LCD_SCOPE_GRID_EN` undefined, pixel (0,0) with sample 200 is BG_COL, and no pixel equals GRID_COL.

Source files
------------

// File: rtl/lcd_scope_pkg.sv
// lcd_scope_pkg: panel geometry, scan states and default colours for the LT24 scope display
package lcd_scope_pkg;
  localparam int LCD_W = 240;
  localparam int LCD_H = 320;
  localparam int GRID_DIV_DEF = 40;
  localparam logic [15:0] TRACE_DEF = 16'h07E0;
  localparam logic [15:0] GRID_DEF = 16'h4208;
  localparam logic [15:0] BG_DEF = 16'h0000;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, DONE} state_t;
endpackage

// File: rtl/lcd_frame_sequencer_if.sv
// lcd_frame_sequencer_if: frame control, sample-buffer read and LT24 pixel-port signals
interface lcd_frame_sequencer_if #(parameter int SAMPLE_W = 8);
  logic frameStart;
  logic frameBusy;
  logic frameDone;
  logic sampRd;
  logic [8:0] sampAddr;
  logic [SAMPLE_W-1:0] sampData;
  logic [7:0] xAddr;
  logic [8:0] yAddr;
  logic [15:0] pixelData;
  logic pixelWrite;
  logic pixelReady;
  modport master (
    input frameStart, sampData, pixelReady,
    output frameBusy, frameDone, sampRd, sampAddr, xAddr, yAddr, pixelData, pixelWrite
  );
  modport slave (
    output frameStart, sampData, pixelReady,
    input frameBusy, frameDone, sampRd, sampAddr, xAddr, yAddr, pixelData, pixelWrite
  );
endinterface

// File: rtl/raster_scan_counter.sv
// raster_scan_counter: column/row scan counters with row/frame-end flags; LCD_SCOPE_GRID_EN adds graticule phase counters
module raster_scan_counter
  import lcd_scope_pkg::*;
#(
  parameter int W = LCD_W,
  parameter int H = LCD_H,
  parameter int G = GRID_DIV_DEF
) (
  input logic clock,
  input logic rstApp,
  input logic clr,
  input logic en,
  output logic [7:0] x,
  output logic [8:0] y,
  output logic [7:0] nx,
  output logic row_end,
  output logic frame_end,
  output logic grid,
  output logic ngrid
);
  logic [8:0] ny;
  assign row_end = x == 8'(W - 1);
  assign frame_end = row_end && y == 9'(H - 1);
  assign nx = row_end ? '0 : x + 8'd1;
  assign ny = frame_end ? '0 : row_end ? y + 9'd1 : y;
  always_ff @(posedge clock)
    if (rstApp || clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      x <= nx;
      y <= ny;
    end
`ifdef LCD_SCOPE_GRID_EN
  logic [7:0] gx, ngx;
  logic [8:0] gy, ngy;
  assign ngx = row_end || gx == 8'(G - 1) ? '0 : gx + 8'd1;
  assign ngy = frame_end ? '0 : !row_end ? gy : gy == 9'(G - 1) ? '0 : gy + 9'd1;
  always_ff @(posedge clock)
    if (rstApp || clr) begin
      gx <= '0;
      gy <= '0;
    end else if (en) begin
      gx <= ngx;
      gy <= ngy;
    end
  assign grid = gx == '0 || gy == '0 || row_end || y == 9'(H - 1);
  assign ngrid = ngx == '0 || ngy == '0 || nx == 8'(W - 1) || ny == 9'(H - 1);
`else
  assign grid = 1'b0;
  assign ngrid = 1'b0;
`endif
endmodule

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: stall-safe LT24 frame raster scan with trace/graticule colouring; graticule needs LCD_SCOPE_GRID_EN
module lcd_frame_sequencer
  import lcd_scope_pkg::*;
#(
  parameter int WIDTH = LCD_W,
  parameter int HEIGHT = LCD_H,
  parameter int SAMPLE_W = 8,
  parameter int GRID_DIV = GRID_DIV_DEF,
  parameter logic [15:0] TRACE_COL = TRACE_DEF,
  parameter logic [15:0] GRID_COL = GRID_DEF,
  parameter logic [15:0] BG_COL = BG_DEF
) (
  input logic clock,
  input logic rstApp,
  lcd_frame_sequencer_if.master bus
);
  state_t state, nxt;
  logic [7:0] x, nx, cur, lo, hi, amp, prv, lo_n, hi_n;
  logic [8:0] y;
  logic row_end, frame_end, grid, ngrid, xfer;
  logic busy_n, done_n, rd_n, wr_n;
  logic [15:0] pix_n;
  function automatic logic [15:0] colour(input logic [7:0] px, input logic g, input logic [7:0] l, input logic [7:0] h);
    return (px >= l && px <= h) ? TRACE_COL : g ? GRID_COL : BG_COL;
  endfunction
  assign xfer = bus.pixelWrite && bus.pixelReady;
  raster_scan_counter #(.W(WIDTH), .H(HEIGHT), .G(GRID_DIV)) u_scan (
    .clock(clock),
    .rstApp(rstApp),
    .clr(state == IDLE),
    .en(xfer),
    .x(x),
    .y(y),
    .nx(nx),
    .row_end(row_end),
    .frame_end(frame_end),
    .grid(grid),
    .ngrid(ngrid)
  );
  always_ff @(posedge clock)
    state <= rstApp ? IDLE : nxt;
  always_comb
    case (state)
      IDLE: nxt = bus.frameStart ? FETCH : IDLE;
      FETCH: nxt = LOAD;
      LOAD: nxt = WRITE;
      WRITE: nxt = !xfer ? WRITE : frame_end ? DONE : row_end ? FETCH : WRITE;
      default: nxt = IDLE;
    endcase
  assign amp = (bus.sampData > SAMPLE_W'(WIDTH - 1)) ? 8'(WIDTH - 1) : 8'(bus.sampData);
  assign prv = (y == '0) ? amp : cur;
  assign lo_n = (prv < amp) ? prv : amp;
  assign hi_n = (prv < amp) ? amp : prv;
  always_ff @(posedge clock)
    if (rstApp) begin
      cur <= '0;
      lo <= '0;
      hi <= '0;
    end else if (state == LOAD) begin
      cur <= amp;
      lo <= lo_n;
      hi <= hi_n;
    end
  always_comb begin
    busy_n = nxt == FETCH || nxt == LOAD || nxt == WRITE;
    done_n = nxt == DONE;
    rd_n = nxt == FETCH;
    wr_n = nxt == WRITE;
    pix_n = (state == LOAD) ? colour(x, grid, lo_n, hi_n) : xfer ? colour(nx, ngrid, lo, hi) : bus.pixelData;
  end
  always_ff @(posedge clock)
    if (rstApp) {bus.frameBusy, bus.frameDone, bus.sampRd, bus.pixelWrite, bus.pixelData} <= '0;
    else {bus.frameBusy, bus.frameDone, bus.sampRd, bus.pixelWrite, bus.pixelData} <= {busy_n, done_n, rd_n, wr_n, pix_n};
  assign bus.sampAddr = y;
  assign bus.xAddr = x;
  assign bus.yAddr = y;
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb_lcd_frame_sequencer: randomized self-checking bench against a raster-order pixel model
module tb_lcd_frame_sequencer;
  localparam int W = 128;
  localparam int H = 40;
  localparam int GD = 10;
  localparam int NPIX = W * H;
  localparam int FRAME = H * (W + 2);
  localparam logic [15:0] TC = 16'h07E0;
  localparam logic [15:0] GC = 16'h4208;
  localparam logic [15:0] BC = 16'h0000;
  logic clock;
  logic rstApp;
  logic [7:0] rd_q;
  logic [7:0] samp [H];
  logic [15:0] cap [NPIX];
  int ncmp = 0;
  int nerr = 0;
  lcd_frame_sequencer_if #(.SAMPLE_W(8)) bus ();
  lcd_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .SAMPLE_W(8), .GRID_DIV(GD),
    .TRACE_COL(TC), .GRID_COL(GC), .BG_COL(BC)
  ) dut (
    .clock(clock),
    .rstApp(rstApp),
    .bus(bus)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) if (bus.sampRd) rd_q <= samp[bus.sampAddr];
  assign bus.sampData = rd_q;
  function automatic int sat(input int s);
    return (s > W - 1) ? W - 1 : s;
  endfunction
  function automatic logic [15:0] exp_pix(input int x, input int y);
    int c, p;
    c = sat(int'(samp[y]));
    p = (y == 0) ? c : sat(int'(samp[y - 1]));
    if (x >= (p < c ? p : c) && x <= (p < c ? c : p)) return TC;
`ifdef LCD_SCOPE_GRID_EN
    if (x % GD == 0 || y % GD == 0 || x == W - 1 || y == H - 1) return GC;
`endif
    return BC;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic zero_check(input string tag);
    chk({tag, "_frameBusy"}, bus.frameBusy, 0);
    chk({tag, "_frameDone"}, bus.frameDone, 0);
    chk({tag, "_sampRd"}, bus.sampRd, 0);
    chk({tag, "_sampAddr"}, bus.sampAddr, 0);
    chk({tag, "_xAddr"}, bus.xAddr, 0);
    chk({tag, "_yAddr"}, bus.yAddr, 0);
    chk({tag, "_pixelData"}, bus.pixelData, 0);
    chk({tag, "_pixelWrite"}, bus.pixelWrite, 0);
  endtask
  task automatic run_frame(input int stall, input int pulse_cyc);
    int k, cyc, first;
    logic [33:0] prev;
    logic hold;
    k = 0;
    first = -1;
    hold = 1'b0;
    prev = '0;
    @(negedge clock);
    bus.frameStart = 1'b1;
    @(negedge clock);
    bus.frameStart = 1'b0;
    chk("sampRd_after_start", bus.sampRd, 1);
    chk("sampAddr_row0", bus.sampAddr, 0);
    for (cyc = 1; cyc < FRAME * 3 && !bus.frameDone; cyc++) begin
      if (hold) chk("stall_hold", {bus.pixelWrite, bus.yAddr, bus.xAddr, bus.pixelData}, prev);
      bus.frameStart = (cyc == pulse_cyc);
      bus.pixelReady = ($urandom_range(99) >= stall);
      if (bus.pixelWrite && first < 0) first = cyc;
      if (bus.pixelWrite && bus.pixelReady) begin
        if (k < NPIX) begin
          chk("pixel", {bus.yAddr, bus.xAddr, bus.pixelData}, {9'(k / W), 8'(k % W), exp_pix(k % W, k / W)});
          cap[k] = bus.pixelData;
        end
        k++;
      end
      hold = bus.pixelWrite && !bus.pixelReady;
      prev = {bus.pixelWrite, bus.yAddr, bus.xAddr, bus.pixelData};
      @(negedge clock);
    end
    bus.frameStart = 1'b0;
    chk("first_write_cycle", first, 3);
    chk("transfer_count", k, NPIX);
    if (stall == 0) chk("done_cycle", cyc, FRAME + 1);
    chk("done_pulse", bus.frameDone, 1);
    chk("busy_low_at_done", bus.frameBusy, 0);
    @(negedge clock);
    chk("done_one_cycle", bus.frameDone, 0);
    repeat (3) @(negedge clock);
    chk("idle_after_done", bus.frameBusy, 0);
  endtask
  initial begin
    int ngrid;
    rstApp = 1'b1;
    bus.frameStart = 1'b0;
    bus.pixelReady = 1'b0;
    repeat (3) @(negedge clock);
    zero_check("reset");
    rstApp = 1'b0;
    foreach (samp[i]) samp[i] = 8'd100;
    run_frame(0, 0);
    chk("col100_row0", cap[100], TC);
    chk("col100_rowlast", cap[(H - 1) * W + 100], TC);
`ifdef LCD_SCOPE_GRID_EN
    chk("x0y1_grid", cap[W], GC);
`else
    chk("x0y1_bg", cap[W], BC);
`endif
    chk("x1y1_bg", cap[W + 1], BC);
    foreach (samp[i]) samp[i] = 8'($urandom_range(255));
    run_frame(30, 0);
    foreach (samp[i]) samp[i] = 8'($urandom_range(255));
    samp[0] = 8'd200;
    samp[3] = 8'd50;
    samp[4] = 8'd250;
    samp[5] = 8'd10;
    run_frame(0, 0);
    chk("row4_last_trace", cap[4 * W + W - 1], TC);
    chk("row4_join_lo", cap[4 * W + 50], TC);
    chk("row4_below_join", cap[4 * W + 49] != TC, 1);
    chk("row5_x10_trace", cap[5 * W + 10], TC);
    chk("row5_last_trace", cap[5 * W + W - 1], TC);
    chk("row5_x9_not_trace", cap[5 * W + 9] != TC, 1);
`ifdef LCD_SCOPE_GRID_EN
    chk("x0y0_grid", cap[0], GC);
`else
    chk("x0y0_bg_nogrid", cap[0], BC);
    ngrid = 0;
    foreach (cap[i]) if (cap[i] == GC) ngrid++;
    chk("no_grid_pixels", ngrid, 0);
`endif
    foreach (samp[i]) samp[i] = 8'($urandom_range(255));
    run_frame(0, 10);
    @(negedge clock);
    bus.pixelReady = 1'b1;
    bus.frameStart = 1'b1;
    @(negedge clock);
    bus.frameStart = 1'b0;
    for (int i = 0; i < FRAME && !(bus.pixelWrite && bus.yAddr == 9'd20 && bus.xAddr == 8'(W / 2)); i++)
      @(negedge clock);
    chk("reach_mid_row20", {bus.pixelWrite, bus.yAddr, bus.xAddr}, {1'b1, 9'd20, 8'(W / 2)});
    rstApp = 1'b1;
    @(negedge clock);
    zero_check("midreset");
    rstApp = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_after_midreset", {bus.frameBusy, bus.pixelWrite, bus.sampRd}, 0);
    foreach (samp[i]) samp[i] = 8'($urandom_range(255));
    run_frame(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
